// File: rtl/ifetch_stage.sv
// ============================================================================
//  Module      : ifetch_stage
//  Description : Instruction fetch front end. Issues sequential PCs on a
//                pipelined instruction-memory port and buffers responses in
//                an in-order queue feeding the F-stage entry. Optional
//                zero-latency response bypass under IFETCH_BYPASS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ifetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013,
    parameter int          N_STAGES = 5,
    parameter int          STAGE_F  = 0
) (
    input  logic                clk,
    input  logic                grst,
    input  logic [N_STAGES-1:0] stall,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    output logic                imem_req,
    output logic [31:0]         imem_addr,
    input  logic                imem_gnt,
    input  logic                imem_rvalid,
    input  logic [31:0]         imem_rdata,
    output logic                valid_out,
    output logic [31:0]         pc_out,
    output logic [31:0]         instr_out
);

    localparam int                   c_ptr_w  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int                   c_cnt_w  = c_ptr_w + 1;
    localparam logic [c_cnt_w:0]     c_qdepth = (c_cnt_w+1)'(QDEPTH);
    localparam logic [c_ptr_w-1:0]   c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0]   c_cnt_one = c_cnt_w'(1);

    logic [31:0]          r_fetch_pc;
    logic [c_cnt_w-1:0]   r_outst;
    logic [c_cnt_w-1:0]   r_drop;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_ptr_w-1:0]   r_q_rd;
    logic [c_ptr_w-1:0]   r_q_wr;
    logic [c_ptr_w-1:0]   r_t_rd;
    logic [c_ptr_w-1:0]   r_t_wr;
    logic [31:0]          r_q_pc   [QDEPTH];
    logic [31:0]          r_q_insn [QDEPTH];
    logic [31:0]          r_tag    [QDEPTH];

    logic w_stall_f;
    logic w_credit;
    logic w_grant;
    logic w_rv;
    logic w_take;
    logic w_drop_rsp;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_unused;

    assign w_stall_f  = stall[STAGE_F];
    assign w_credit   = ({1'b0, r_outst} + {1'b0, r_count}) < c_qdepth;
    assign imem_req   = grst && !redirect_valid && w_credit;
    assign imem_addr  = r_fetch_pc;
    assign w_grant    = imem_req && imem_gnt;
    // Responses with nothing outstanding are protocol errors and are ignored.
    assign w_rv       = imem_rvalid && (r_outst != '0);
    assign w_take     = w_rv && !redirect_valid && (r_drop == '0);
    assign w_drop_rsp = w_rv && !redirect_valid && (r_drop != '0);

`ifdef IFETCH_BYPASS_EN
    assign w_bypass = w_take && (r_count == '0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_push   = w_take && !(w_bypass && !w_stall_f);
    assign w_pop    = (r_count != '0) && !w_stall_f && !redirect_valid;
    assign w_unused = ^{stall, redirect_pc[1:0]};

    always_comb begin
        valid_out = 1'b0;
        pc_out    = '0;
        instr_out = NOP_INSN;
        if (r_count != '0) begin
            valid_out = 1'b1;
            pc_out    = r_q_pc[r_q_rd];
            instr_out = r_q_insn[r_q_rd];
        end else if (w_bypass) begin
            valid_out = 1'b1;
            pc_out    = r_tag[r_t_rd];
            instr_out = imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!grst) begin
            r_fetch_pc <= RESET_PC;
            r_outst    <= '0;
            r_drop     <= '0;
            r_count    <= '0;
            r_q_rd     <= '0;
            r_q_wr     <= '0;
            r_t_rd     <= '0;
            r_t_wr     <= '0;
        end else begin
            r_outst <= r_outst + c_cnt_w'(w_grant) - c_cnt_w'(w_rv);
            if (redirect_valid) begin
                // Every still-outstanding request belongs to the killed path;
                // requests already marked for dropping are part of r_outst.
                r_fetch_pc <= {redirect_pc[31:2], 2'b00};
                r_drop     <= r_outst - c_cnt_w'(w_rv);
                r_count    <= '0;
                r_q_rd     <= '0;
                r_q_wr     <= '0;
                r_t_rd     <= '0;
                r_t_wr     <= '0;
            end else begin
                if (w_grant) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                    r_t_wr     <= r_t_wr + c_ptr_one;
                end
                if (w_drop_rsp)
                    r_drop <= r_drop - c_cnt_one;
                if (w_take)
                    r_t_rd <= r_t_rd + c_ptr_one;
                if (w_push)
                    r_q_wr <= r_q_wr + c_ptr_one;
                if (w_pop)
                    r_q_rd <= r_q_rd + c_ptr_one;
                r_count <= r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grst && !redirect_valid) begin
            if (w_grant)
                r_tag[r_t_wr] <= r_fetch_pc;
            if (w_push) begin
                r_q_pc[r_q_wr]   <= r_tag[r_t_rd];
                r_q_insn[r_q_wr] <= imem_rdata;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_stage.sv
// ============================================================================
//  Module      : tb_ifetch_stage
//  Description : Directed self-checking bench for ifetch_stage with a
//                pipelined memory model (data = address + 0x1000_0000).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ifetch_stage;

    localparam logic [31:0] c_nop = 32'h0000_0013;
    localparam logic [31:0] c_ofs = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        grst;
    logic [4:0]  stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        valid_out;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        mem_hold;

    logic [31:0] pend[$];
    logic [31:0] gl[$];
    logic [31:0] dl[$];
    logic [31:0] di[$];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    ifetch_stage #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2),
        .NOP_INSN (32'h0000_0013),
        .N_STAGES (5),
        .STAGE_F  (0)
    ) u_dut (
        .clk            (clk),
        .grst           (grst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .valid_out      (valid_out),
        .pc_out         (pc_out),
        .instr_out      (instr_out)
    );

    // In-order memory: responds the cycle after grant unless held.
    always @(posedge clk) begin
        if (!grst) begin
            pend.delete();
            imem_rvalid <= 1'b0;
        end else begin
            if (imem_rvalid)
                void'(pend.pop_front());
            if (imem_req && imem_gnt)
                pend.push_back(imem_addr);
            if (pend.size() > 0 && !mem_hold) begin
                imem_rvalid <= 1'b1;
                imem_rdata  <= pend[0] + c_ofs;
            end else begin
                imem_rvalid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (grst) begin
            if (imem_req && imem_gnt)
                gl.push_back(imem_addr);
            if (valid_out && !stall[0] && !redirect_valid) begin
                dl.push_back(pc_out);
                di.push_back(instr_out);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] at(input logic [31:0] q[$], input int i);
        if (i < q.size())
            return q[i];
        return 32'hxxxx_xxxx;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        gl.delete();
        dl.delete();
        di.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        grst = 1'b0; stall = '0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_gnt = 1'b1; mem_hold = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_instr", instr_out, c_nop);
        chk("rst_pc",    pc_out, 32'd0);
        chk("rst_req",   32'(imem_req), 32'd0);

        tick(); grst = 1'b1;
        @(negedge clk);
        chk("first_req",  32'(imem_req), 32'd1);
        chk("first_addr", imem_addr, 32'h0);

        // Sequential stream
        repeat (20) tick();
        @(negedge clk);
        for (int i = 0; i < 8; i++)
            chk("seq_pc", at(dl, i), 32'(4 * i));
        for (int i = 0; i < 2; i++)
            chk("seq_insn", at(di, i), 32'(4 * i) + c_ofs);

        // Stall for 5 cycles: credits exhausted, queue full
        tick(); stall = 5'b00001;
        repeat (5) tick();
        @(negedge clk);
        chk("stall_req",   32'(imem_req), 32'd0);
        chk("stall_valid", 32'(valid_out), 32'd1);
        chk("stall_credit", 32'(gl.size() - dl.size()), 32'd2);
        tick(); stall = '0;
        repeat (20) tick();
        @(negedge clk);
        chk("stream_len", 32'(dl.size() >= 16), 32'd1);
        for (int i = 0; i < dl.size(); i++)
            chk("stream_pc", dl[i], 32'(4 * i));

        // Reset with the queue full
        tick(); stall = 5'b00001;
        repeat (3) tick();
        @(negedge clk);
        chk("full_valid", 32'(valid_out), 32'd1);
        chk("full_req",   32'(imem_req), 32'd0);
        tick(); grst = 1'b0; stall = '0; clear_logs();
        @(negedge clk);
        chk("rst2_req_low", 32'(imem_req), 32'd0);
        tick(); grst = 1'b1; stall = 5'b00001;
        @(negedge clk);
        chk("rst2_valid", 32'(valid_out), 32'd0);
        chk("rst2_instr", instr_out, c_nop);
        chk("rst2_pc",    pc_out, 32'd0);
        chk("rst2_req",   32'(imem_req), 32'd1);
        chk("rst2_addr",  imem_addr, 32'h0);

        // Redirect with 0x8 and 0xC outstanding
        repeat (3) tick();
        stall = '0; mem_hold = 1'b1;
        repeat (3) tick();
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
        @(negedge clk);
        chk("redir_req",   32'(imem_req), 32'd0);
        chk("redir_valid", 32'(valid_out), 32'd0);
        chk("redir_d1",    at(dl, 1), 32'h4);
        chk("redir_g2",    at(gl, 2), 32'h8);
        chk("redir_g3",    at(gl, 3), 32'hC);
        tick(); redirect_valid = 1'b0; mem_hold = 1'b0; clear_logs();
        @(negedge clk);
        chk("redir_addr",      imem_addr, 32'h0000_0100);
        chk("redir_req_after", 32'(imem_req), 32'd0);
        repeat (10) tick();
        @(negedge clk);
        chk("redir_grant0", at(gl, 0), 32'h0000_0100);
        chk("redir_pc0",    at(dl, 0), 32'h0000_0100);
        chk("redir_insn0",  at(di, 0), 32'h1000_0100);
        chk("redir_pc1",    at(dl, 1), 32'h0000_0104);

        // Redirect coincident with a response and stall
        for (int k = 0; k < 10 && !imem_rvalid; k++)
            tick();
        chk("coinc_rv_seen", 32'(imem_rvalid), 32'd1);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; stall = 5'b00001;
        @(negedge clk);
        chk("coinc_req", 32'(imem_req), 32'd0);
        tick(); redirect_valid = 1'b0; clear_logs();
        @(negedge clk);
        chk("coinc_valid", 32'(valid_out), 32'd0);
        chk("coinc_req1",  32'(imem_req), 32'd1);
        chk("coinc_addr",  imem_addr, 32'h0000_0200);
        tick(); stall = '0;
        repeat (8) tick();
        @(negedge clk);
        chk("coinc_pc0", at(dl, 0), 32'h0000_0200);

        // Address wrap
        tick(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick(); redirect_valid = 1'b0; clear_logs();
        repeat (10) tick();
        @(negedge clk);
        chk("wrap_g0",    at(gl, 0), 32'hFFFF_FFFC);
        chk("wrap_g1",    at(gl, 1), 32'h0000_0000);
        chk("wrap_pc0",   at(dl, 0), 32'hFFFF_FFFC);
        chk("wrap_pc1",   at(dl, 1), 32'h0000_0000);
        chk("wrap_insn0", at(di, 0), 32'h0FFF_FFFC);
        chk("wrap_insn1", at(di, 1), 32'h1000_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
